// File: rtl/com_bus_arbiter_pkg.sv
// com_bus_arbiter_pkg: shared definitions for the coherence bus arbiter
// (core count, core-index width, FSM encodings, watchdog default).
// The optional ownership watchdog is built only when ARB_TIMEOUT_EN is defined.
package com_bus_arbiter_pkg;

  localparam int ARB_NUM_CORES      = 4;
  localparam int ARB_CORE_W         = $clog2(ARB_NUM_CORES);
  localparam int ARB_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_BACKOFF = 2'd3
  } arb_state_e;

endpackage

// File: rtl/com_bus_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational circular-priority picker. Starting at
// start_i and walking upward (wrapping), the first set bit of req_i wins.
module rr_priority_pick
  import com_bus_arbiter_pkg::*;
#(
  parameter int N = ARB_NUM_CORES,
  parameter int W = ARB_CORE_W
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);

  logic [W-1:0] idx_v;
  logic         found_v;

  // Walk the ring from start_i and keep only the first requester seen.
  always_comb begin
    gnt_o   = '0;
    idx_v   = '0;
    found_v = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_v = W'((int'(start_i) + k) % N);
      if (req_i[idx_v] && !found_v) begin
        gnt_o[idx_v] = 1'b1;
        found_v      = 1'b1;
      end else begin
        found_v = found_v;
      end
    end
  end

  assign valid_o = found_v;

endmodule

// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: central arbiter of the shared coherence bus. Issues one
// processor-side grant (round-robin, no preemption) and one snoop-side grant
// (circular from owner+1), aggregates invalidation acks and Shared flags.
// Define ARB_TIMEOUT_EN to add the ownership watchdog and BACKOFF state.
module com_bus_arbiter
  import com_bus_arbiter_pkg::*;
#(
  parameter int NUM_CORES      = ARB_NUM_CORES,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CORES-1:0]         Com_Bus_Req_proc,
  output logic [NUM_CORES-1:0]         Com_Bus_Gnt_proc,
  input  logic [NUM_CORES-1:0]         Com_Bus_Req_snoop,
  output logic [NUM_CORES-1:0]         Com_Bus_Gnt_snoop,
  input  logic                         Invalidate,
  input  logic [NUM_CORES-1:0]         Invalidation_done,
  output logic                         All_Invalidation_done,
  input  logic [NUM_CORES-1:0]         Shared_local,
  output logic [NUM_CORES-1:0]         Shared,
  output logic [$clog2(NUM_CORES)-1:0] Bus_owner,
  output logic                         Bus_busy,
  output logic                         Arb_timeout
);

  localparam int CW = $clog2(NUM_CORES);
  localparam logic [NUM_CORES-1:0] ONE_V = {{(NUM_CORES-1){1'b0}}, 1'b1};

  arb_state_e           state_q, state_d;
  logic [CW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] gnt_proc_q, gnt_proc_d;
  logic [NUM_CORES-1:0] gnt_snoop_q, gnt_snoop_d;
  logic                 aid_q, aid_d;
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CORES-1:0] bk_snoop_q, bk_snoop_d;
  logic                 tmo_q, tmo_d;
`endif

  logic [NUM_CORES-1:0] owner_oh_s;
  logic [CW-1:0]        owner_inc_s;
  logic                 owner_req_s;
  logic                 snoop_act_s;
  logic                 snoop_hold_s;
  logic [NUM_CORES-1:0] snoop_cand_s;
  logic [NUM_CORES-1:0] proc_pick_gnt_s, snoop_pick_gnt_s;
  logic                 proc_pick_vld_s, snoop_pick_vld_s;
  logic [CW-1:0]        proc_pick_idx_s;

  assign owner_oh_s   = ONE_V << owner_q;
  assign owner_inc_s  = (owner_q == CW'(NUM_CORES - 1)) ? '0 : owner_q + CW'(1);
  assign owner_req_s  = |(Com_Bus_Req_proc & owner_oh_s);
  assign snoop_act_s  = |gnt_snoop_q;
  assign snoop_hold_s = |(Com_Bus_Req_snoop & gnt_snoop_q);
  // The owner never competes for its own snoop slot.
  assign snoop_cand_s = Com_Bus_Req_snoop & ~owner_oh_s;

  rr_priority_pick #(.N(NUM_CORES), .W(CW)) u_proc_pick (
    .req_i   (Com_Bus_Req_proc),
    .start_i (rr_ptr_q),
    .gnt_o   (proc_pick_gnt_s),
    .valid_o (proc_pick_vld_s)
  );

  rr_priority_pick #(.N(NUM_CORES), .W(CW)) u_snoop_pick (
    .req_i   (snoop_cand_s),
    .start_i (owner_inc_s),
    .gnt_o   (snoop_pick_gnt_s),
    .valid_o (snoop_pick_vld_s)
  );

  // Convert the proc picker's one-hot result into a core index.
  always_comb begin
    proc_pick_idx_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (proc_pick_gnt_s[i]) begin
        proc_pick_idx_s = CW'(i);
      end else begin
        proc_pick_idx_s = proc_pick_idx_s;
      end
    end
  end

  // Acks only count while an owner drives Invalidate; owner's own ack is masked.
  assign aid_d = (state_q == ST_OWNED) && Invalidate && (&(Invalidation_done | owner_oh_s));

  // State register: all arbitration state, cleared synchronously by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      aid_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      bk_snoop_q  <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snoop_q <= gnt_snoop_d;
      aid_q       <= aid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bk_snoop_q  <= bk_snoop_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Next-state logic: ownership, release, snoop sub-arbitration, drain.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_proc_d  = gnt_proc_q;
    gnt_snoop_d = gnt_snoop_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    bk_snoop_d  = bk_snoop_q;
    tmo_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_snoop_d = '0;
        if (proc_pick_vld_s) begin
          owner_d    = proc_pick_idx_s;
          gnt_proc_d = proc_pick_gnt_s;
          state_d    = ST_OWNED;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWNED: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (!owner_req_s) begin
          // Release beats any snoop request arriving on the same edge.
          gnt_proc_d = '0;
          rr_ptr_d   = owner_inc_s;
          if (snoop_act_s && snoop_hold_s) begin
            state_d = ST_DRAIN;
          end else begin
            gnt_snoop_d = '0;
            state_d     = ST_IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          gnt_proc_d  = '0;
          gnt_snoop_d = '0;
          bk_snoop_d  = gnt_snoop_q;
          rr_ptr_d    = owner_inc_s;
          tmo_d       = 1'b1;
          state_d     = ST_BACKOFF;
        end
`endif
        else begin
          // A freshly dropped snoop grant stays low one cycle before re-picking.
          if (snoop_act_s) begin
            gnt_snoop_d = snoop_hold_s ? gnt_snoop_q : '0;
          end else begin
            gnt_snoop_d = snoop_pick_vld_s ? snoop_pick_gnt_s : '0;
          end
        end
      end
      ST_DRAIN: begin
        if (!snoop_hold_s) begin
          gnt_snoop_d = '0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
`ifdef ARB_TIMEOUT_EN
      ST_BACKOFF: begin
        if (!owner_req_s && !(|(Com_Bus_Req_snoop & bk_snoop_q))) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BACKOFF;
        end
      end
`endif
      default: begin
        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Output logic: registered grants/flags out, Shared is pure OR of the others.
  always_comb begin
    Com_Bus_Gnt_proc      = gnt_proc_q;
    Com_Bus_Gnt_snoop     = gnt_snoop_q;
    Bus_owner             = owner_q;
    Bus_busy              = (state_q != ST_IDLE);
    All_Invalidation_done = aid_q;
`ifdef ARB_TIMEOUT_EN
    Arb_timeout           = tmo_q;
`else
    Arb_timeout           = 1'b0;
`endif
    Shared                = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      Shared[i] = |(Shared_local & ~(ONE_V << i));
    end
  end

endmodule

// File: doc/com_bus_arbiter.md
# com_bus_arbiter

Central arbiter for the shared coherence bus of the 4-core MESI system. It takes per-core processor-side and snoop-side bus requests from the cache wrappers and issues `Com_Bus_Gnt_proc` / `Com_Bus_Gnt_snoop` back to them. It aggregates per-core `Invalidation_done` into `All_Invalidation_done` and per-core `Shared_local` into each core's `Shared` input. It sits between the four cache wrappers and the common address/data bus.

## Interface
- `NUM_CORES`, 4: number of cache wrappers served; the RTL is verified only at 4.
- `TIMEOUT_CYCLES`, 64: ownership watchdog limit, in cycles. Used only with `ARB_TIMEOUT_EN`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `Com_Bus_Req_proc` input NUM_CORES: processor-side bus request, one bit per core.
- `Com_Bus_Gnt_proc` output NUM_CORES: processor-side grant, one-hot or zero.
- `Com_Bus_Req_snoop` input NUM_CORES: snoop-side request (write-back or data supply), one bit per core.
- `Com_Bus_Gnt_snoop` output NUM_CORES: snoop-side grant, one-hot or zero.
- `Invalidate` input 1: the bus Invalidate line, as driven by the current owner.
- `Invalidation_done` input NUM_CORES: per-core acknowledge of an invalidation.
- `All_Invalidation_done` output 1: every non-owner core has acknowledged.
- `Shared_local` input NUM_CORES: per-core "I hold this line" flag.
- `Shared` output NUM_CORES: `Shared[i]` is the OR of `Shared_local[j]` over all j≠i.
- `Bus_owner` output 2: index of the current processor-side owner.
- `Bus_busy` output 1: high in every state except IDLE.
- `Arb_timeout` output 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, OWNED, DRAIN, BACKOFF. Encoding comes from the shared header.
- IDLE:
  - If any `Com_Bus_Req_proc` bit is high, pick by round-robin, starting at `rr_ptr`.
  - Latch the winner into `Bus_owner`, assert its proc grant, go to OWNED.
  - Snoop requests are ignored in IDLE.
- OWNED:
  - The proc grant is held while the owner's `Com_Bus_Req_proc` stays high.
  - Requests from other cores wait. There is no preemption.
- Snoop sub-arbitration (OWNED only):
  - Applies only when no snoop grant is active.
  - Candidates are the non-owner cores with `Com_Bus_Req_snoop` high. Pick the lowest index in circular order starting at owner+1.
  - The snoop grant is held until that core drops its request, then deasserts.
  - Snoop grant stays low for at least one cycle before the next snoop grant.
  - The owner's own snoop request is ignored.
- Release:
  - When the owner drops its request, the proc grant deasserts and `rr_ptr` becomes owner+1 mod NUM_CORES.
  - If a snoop grant is active, go to DRAIN. Otherwise go to IDLE.
- DRAIN:
  - No new proc or snoop grants are issued.
  - Hold the active snoop grant until its request drops, then go to IDLE.
- Invariant: at most one proc grant and at most one snoop grant at any time, and the two are never to the same core.
- `All_Invalidation_done`:
  - Registered.
  - Next value is 1 only in OWNED with `Invalidate`=1 and `Invalidation_done[j]`=1 for every j≠owner. Otherwise 0.
  - Owner's own `Invalidation_done` is don't-care.
- `Shared`: purely combinational from `Shared_local`, independent of FSM state.
- Reset:
  - All grants 0, `Bus_owner`=0, `Bus_busy`=0, `All_Invalidation_done`=0, `Arb_timeout`=0.
  - `rr_ptr`=0, watchdog counter 0, state IDLE.
  - Reset asserted mid-transaction drops all grants at that edge. Any request still high is re-arbitrated from IDLE after reset deasserts.

## Timing
- Grant latency: a request high at edge N (state IDLE) gives a grant high after edge N.
- Release latency: a request low at edge N gives a grant low after edge N.
- Turnaround: at least one cycle with no proc grant between successive owners, so back-to-back ownership is ≥1 idle cycle apart.
- Snoop grant latency: one cycle from request in OWNED.
- Simultaneous owner release and snoop request: the release wins and no new snoop grant is issued.
- `All_Invalidation_done` lags its inputs by one cycle.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A counter increments every cycle in OWNED and clears on entry to OWNED.
  - When it reaches TIMEOUT_CYCLES−1, both grants deassert, `Arb_timeout` pulses for 1 cycle, `rr_ptr` becomes owner+1, and the FSM goes to BACKOFF.
  - BACKOFF waits until the former owner's proc request and any previously granted snoop request are low, then goes to IDLE.
- Not defined:
  - No counter and no BACKOFF state.
  - `Arb_timeout` tied to 0.
  - Ownership is unbounded.

## Structure
- Shared definitions header (alongside the existing cache defines) holds:
  - NUM_CORES and core-index width.
  - FSM state encodings.
  - TIMEOUT_CYCLES default.
- One sub-module, `rr_priority_pick`: combinational circular-priority picker. Inputs are a request vector and a start index; outputs are a one-hot grant and a valid flag.
- It is instantiated twice: once for proc arbitration (start=`rr_ptr`) and once for snoop arbitration (start=owner+1, owner masked out).

## Test plan
- **Round-robin fairness:** `Com_Bus_Req_proc`=4'b1111, each owner drops its request 3 cycles after grant. Grants go core 0,1,2,3,0, with one idle cycle between each.
- **Snoop during ownership:** core 2 owns the bus; cores 0 and 3 raise snoop requests. Core 3 is granted first and held until it drops, then at least 1 low cycle, then core 0. `Com_Bus_Gnt_proc`=4'b0100 throughout.
- **DRAIN:** core 1 owns and core 3 holds a snoop grant; core 1 drops its request. Proc grant is 0 the next cycle, the snoop grant holds, and the FSM goes to IDLE one cycle after core 3 drops.
- **Invalidation aggregation:** owner 0, `Invalidate`=1, `Invalidation_done`=4'b1110. `All_Invalidation_done`=1 one cycle later. With 4'b0110 it stays 0.
- **Shared:** `Shared_local`=4'b0010 gives `Shared`=4'b1101.
- **Timeout (`ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8):** core 0 holds its request. Grant drops after cycle 8, `Arb_timeout` pulses once, and there is no regrant to core 0 until its request is released and reasserted. Reset asserted mid-ownership clears everything at that edge.
